io_reg_file_ext: RTL and testbench

//  Parametrised core-internal I/O register file for the AVR core: SREG, SP (SPL/SPH), RAMPD/X/Y/Z, EIND.

---
 rtl/io_reg_file_ext_pkg.sv | 34 +++
 rtl/io_reg_file_ext_if.sv | 18 +
 rtl/io_reg_file_ext_ccp.sv | 75 +++++++
 rtl/io_reg_file_ext.sv | 203 ++++++++++++++++++++
 tb/tb_io_reg_file_ext.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_reg_file_ext_pkg.sv
// io_reg_pkg: shared constants for the core-internal I/O register file.
//   - I/O addresses of every register decoded by io_reg_file_ext
//   - CCP unlock key
//   - sp_step encoding and CCP FSM state type
package io_reg_pkg;

  localparam logic [5:0] ADR_SPLIML = 6'h32;
  localparam logic [5:0] ADR_SPLIMH = 6'h33;
  localparam logic [5:0] ADR_CCP    = 6'h34;
  localparam logic [5:0] ADR_RAMPD  = 6'h38;
  localparam logic [5:0] ADR_RAMPX  = 6'h39;
  localparam logic [5:0] ADR_RAMPY  = 6'h3A;
  localparam logic [5:0] ADR_RAMPZ  = 6'h3B;
  localparam logic [5:0] ADR_EIND   = 6'h3C;
  localparam logic [5:0] ADR_SPL    = 6'h3D;
  localparam logic [5:0] ADR_SPH    = 6'h3E;
  localparam logic [5:0] ADR_SREG   = 6'h3F;

  localparam logic [7:0] CCP_KEY = 8'hD8;

  // Number of bytes moved by one SP count operation.
  typedef enum logic [1:0] {
    SP_STEP_NONE = 2'd0,
    SP_STEP_1    = 2'd1,
    SP_STEP_2    = 2'd2,
    SP_STEP_3    = 2'd3
  } sp_step_e;

  typedef enum logic {
    CCP_IDLE = 1'b0,
    CCP_OPEN = 1'b1
  } ccp_state_e;

endpackage

// File: rtl/io_reg_file_ext_if.sv
// io_reg_file_ext_if: core I/O bus between the core (master) and the register file (slave).
//   adr     6  I/O address            (master -> slave)
//   iowe    1  write strobe           (master -> slave)
//   iore    1  read strobe            (master -> slave)
//   dbusout 8  write data             (master -> slave)
//   dbusin  8  read data, 0 if no hit (slave -> master)
//   io_hit  1  read hits this block   (slave -> master)
interface io_reg_file_ext_if;
  logic [5:0] adr;
  logic       iowe;
  logic       iore;
  logic [7:0] dbusout;
  logic [7:0] dbusin;
  logic       io_hit;

  modport master (output adr, iowe, iore, dbusout, input dbusin, io_hit);
  modport slave  (input adr, iowe, iore, dbusout, output dbusin, io_hit);
endinterface

// File: rtl/io_reg_file_ext_ccp.sv
// io_ccp_ctrl: configuration-change-protection window.
//   Writing CCP_KEY to the CCP register opens a window of CCP_WINDOW enabled
//   cycles during which protected registers accept writes.
// Ports:
//   cp2        in   core clock
//   ireset     in   asynchronous active-low reset
//   cp2en      in   clock enable, state holds when 0
//   ccp_wr     in   write strobe decoded for the CCP address
//   wr_data    in   write data
//   ccp_active out  window open
module io_ccp_ctrl
  import io_reg_pkg::*;
#(
  parameter int CCP_WINDOW = 4
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic       cp2en,
  input  logic       ccp_wr,
  input  logic [7:0] wr_data,
  output logic       ccp_active
);

  localparam logic [3:0] WIN = 4'(CCP_WINDOW);

  ccp_state_e state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_reg <= CCP_IDLE;
      cnt_reg   <= 4'd0;
    end else if (cp2en) begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CCP_IDLE: begin
        if (ccp_wr && wr_data == CCP_KEY) begin
          state_next = CCP_OPEN;
          cnt_next   = WIN;
        end
      end
      CCP_OPEN: begin
        if (ccp_wr) begin
          // Rewriting the key restarts the window; anything else aborts it.
          if (wr_data == CCP_KEY) begin
            cnt_next = WIN;
          end else begin
            state_next = CCP_IDLE;
            cnt_next   = 4'd0;
          end
        end else if (cnt_reg <= 4'd1) begin
          // Last open cycle: the counter reaches 0 on this edge.
          state_next = CCP_IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = CCP_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign ccp_active = (state_reg == CCP_OPEN);

endmodule

// File: rtl/io_reg_file_ext.sv
// io_reg_file_ext: core-internal I/O register file (SREG, SP, RAMPD/X/Y/Z, EIND, CCP).
// Optional feature macro: IO_REG_FILE_EXT_STACK_LIMIT_EN
//   defined   -> SPLIM registers at 0x32/0x33 (CCP protected) and a sticky stack fault
//   undefined -> no limit check, 0x32/0x33 not decoded, stk_fault = 0
// Ports:
//   cp2, ireset (async active-low), cp2en (clock enable)
//   bus          I/O bus slave (adr, iowe, iore, dbusout, dbusin, io_hit)
//   sreg_fl_in / sreg_fl_wr_en   per-flag SREG updates from the ALU
//   sp_en / sp_ndown_up / sp_step  SP count by 0..3 bytes
//   sp_out, sreg_out, ramp*_out, eind_out   register contents, zero-extended
//   ccp_active   CCP window open
//   stk_fault / stk_ack   sticky stack-limit fault and its clear
module io_reg_file_ext
  import io_reg_pkg::*;
#(
  parameter int SP_WIDTH   = 16,
  parameter int RAMP_WIDTH = 1,
  parameter int PC22B      = 0,
  parameter int EIND_WIDTH = 1,
  parameter int CCP_WINDOW = 4
) (
  input  logic                 cp2,
  input  logic                 ireset,
  input  logic                 cp2en,
  io_reg_file_ext_if.slave     bus,
  input  logic [7:0]           sreg_fl_in,
  input  logic [7:0]           sreg_fl_wr_en,
  output logic [7:0]           sreg_out,
  input  logic                 sp_en,
  input  logic                 sp_ndown_up,
  input  logic [1:0]           sp_step,
  output logic [15:0]          sp_out,
  output logic [7:0]           rampd_out,
  output logic [7:0]           rampx_out,
  output logic [7:0]           rampy_out,
  output logic [7:0]           rampz_out,
  output logic [7:0]           eind_out,
  output logic                 ccp_active,
  output logic                 stk_fault,
  input  logic                 stk_ack
);

  localparam logic EIND_IMPL = (PC22B != 0);

  // Write decode
  logic wr_spl, wr_sph, wr_sreg, wr_eind, wr_ccp;
  assign wr_spl  = bus.iowe && (bus.adr == ADR_SPL);
  assign wr_sph  = bus.iowe && (bus.adr == ADR_SPH);
  assign wr_sreg = bus.iowe && (bus.adr == ADR_SREG);
  assign wr_eind = bus.iowe && (bus.adr == ADR_EIND);
  assign wr_ccp  = bus.iowe && (bus.adr == ADR_CCP);

  io_ccp_ctrl #(.CCP_WINDOW(CCP_WINDOW)) u_ccp (
    .cp2        (cp2),
    .ireset     (ireset),
    .cp2en      (cp2en),
    .ccp_wr     (wr_ccp),
    .wr_data    (bus.dbusout),
    .ccp_active (ccp_active)
  );

  // ---------------------------------------------------------------- SREG
  logic [7:0] sreg_reg, sreg_next;

  for (genvar gi = 0; gi < 8; gi++) begin : g_sreg_bit
    // A bus write to SREG replaces the whole byte and masks the ALU flags.
    assign sreg_next[gi] = wr_sreg           ? bus.dbusout[gi] :
                           sreg_fl_wr_en[gi] ? sreg_fl_in[gi]  : sreg_reg[gi];
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset)    sreg_reg <= 8'h00;
    else if (cp2en) sreg_reg <= sreg_next;
  end
  assign sreg_out = sreg_reg;

  // ---------------------------------------------------------------- RAMPx
  logic [3:0][7:0] ramp_val;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ramp
    logic [RAMP_WIDTH-1:0] ramp_reg;
    logic                  wr_this;
    assign wr_this = bus.iowe && (bus.adr == ADR_RAMPD + 6'(gi));
    always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset)               ramp_reg <= '0;
      else if (cp2en && wr_this) ramp_reg <= bus.dbusout[RAMP_WIDTH-1:0];
    end
    assign ramp_val[gi] = 8'(ramp_reg);
  end

  assign rampd_out = ramp_val[0];
  assign rampx_out = ramp_val[1];
  assign rampy_out = ramp_val[2];
  assign rampz_out = ramp_val[3];

  // ---------------------------------------------------------------- EIND
  logic [7:0] eind_val;

  if (EIND_IMPL) begin : g_eind
    logic [EIND_WIDTH-1:0] eind_reg;
    always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset)                             eind_reg <= '0;
      else if (cp2en && wr_eind && ccp_active) eind_reg <= bus.dbusout[EIND_WIDTH-1:0];
    end
    assign eind_val = 8'(eind_reg);
  end else begin : g_no_eind
    assign eind_val = 8'h00;
  end
  assign eind_out = eind_val;

  // ---------------------------------------------------------------- stack limit
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
  logic [15:0] splim_reg;
  logic        stk_fault_reg;
  logic        fault_set;
  logic        wr_splim_l, wr_splim_h;
  assign wr_splim_l = bus.iowe && (bus.adr == ADR_SPLIML) && ccp_active;
  assign wr_splim_h = bus.iowe && (bus.adr == ADR_SPLIMH) && ccp_active;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      splim_reg     <= 16'h0000;
      stk_fault_reg <= 1'b0;
    end else if (cp2en) begin
      if (wr_splim_l) splim_reg[7:0]  <= bus.dbusout;
      if (wr_splim_h) splim_reg[15:8] <= bus.dbusout;
      // A fresh fault outranks the acknowledge arriving in the same cycle.
      if (fault_set)    stk_fault_reg <= 1'b1;
      else if (stk_ack) stk_fault_reg <= 1'b0;
    end
  end
  assign stk_fault = stk_fault_reg;
`else
  logic unused_stk_ack;
  assign unused_stk_ack = stk_ack;
  assign stk_fault      = 1'b0;
`endif

  // ---------------------------------------------------------------- SP
  logic [SP_WIDTH-1:0] sp_reg, sp_next, step_ext, sp_inc, sp_dec;
  assign step_ext = SP_WIDTH'(sp_step);
  assign sp_inc   = sp_reg + step_ext;
  assign sp_dec   = sp_reg - step_ext;

  always_comb begin
    sp_next = sp_reg;
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
    fault_set = 1'b0;
`endif
    if (wr_spl || wr_sph) begin
      // Software writes win over the hardware count in the same cycle.
      if (wr_spl) sp_next[7:0]          = bus.dbusout;
      if (wr_sph) sp_next[SP_WIDTH-1:8] = bus.dbusout[SP_WIDTH-9:0];
    end else if (sp_en && sp_step != SP_STEP_NONE) begin
      if (sp_ndown_up) begin
        sp_next = sp_inc;
      end else begin
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
        // Underflow (borrow) or landing below the limit is refused.
        if (sp_reg < step_ext || 16'(sp_dec) < splim_reg) fault_set = 1'b1;
        else                                               sp_next   = sp_dec;
`else
        sp_next = sp_dec;
`endif
      end
    end
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset)    sp_reg <= '0;
    else if (cp2en) sp_reg <= sp_next;
  end
  assign sp_out = 16'(sp_reg);

  // ---------------------------------------------------------------- read mux
  logic       rd_hit;
  logic [7:0] rd_data;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 8'h00;
    case (bus.adr)
      ADR_RAMPD: begin rd_hit = 1'b1;      rd_data = ramp_val[0]; end
      ADR_RAMPX: begin rd_hit = 1'b1;      rd_data = ramp_val[1]; end
      ADR_RAMPY: begin rd_hit = 1'b1;      rd_data = ramp_val[2]; end
      ADR_RAMPZ: begin rd_hit = 1'b1;      rd_data = ramp_val[3]; end
      ADR_EIND:  begin rd_hit = EIND_IMPL; rd_data = eind_val;    end
      ADR_SPL:   begin rd_hit = 1'b1;      rd_data = sp_out[7:0];  end
      ADR_SPH:   begin rd_hit = 1'b1;      rd_data = sp_out[15:8]; end
      ADR_SREG:  begin rd_hit = 1'b1;      rd_data = sreg_reg;    end
      ADR_CCP:   begin rd_hit = 1'b1;      rd_data = {7'b0, ccp_active}; end
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
      ADR_SPLIML: begin rd_hit = 1'b1;     rd_data = splim_reg[7:0];  end
      ADR_SPLIMH: begin rd_hit = 1'b1;     rd_data = splim_reg[15:8]; end
`endif
      default: begin rd_hit = 1'b0;        rd_data = 8'h00; end
    endcase
  end

  assign bus.io_hit = bus.iore && rd_hit;
  assign bus.dbusin = bus.io_hit ? rd_data : 8'h00;

endmodule

// File: tb/tb_io_reg_file_ext.sv
// Testbench for io_reg_file_ext: directed vectors, a behavioural model checked
// every cycle, and hand-computed literal expectations.
module tb_io_reg_file_ext;
  import io_reg_pkg::*;

  localparam int SPW = 12;
  localparam int RW  = 1;
  localparam int EW  = 1;
  localparam int WIN = 4;

  logic        cp2 = 1'b0;
  logic        ireset = 1'b0;
  logic        cp2en = 1'b1;
  logic [7:0]  sreg_fl_in = 8'h00, sreg_fl_wr_en = 8'h00;
  logic [7:0]  sreg_out;
  logic        sp_en = 1'b0, sp_ndown_up = 1'b0;
  logic [1:0]  sp_step = 2'd0;
  logic [15:0] sp_out;
  logic [7:0]  rampd_out, rampx_out, rampy_out, rampz_out, eind_out;
  logic        ccp_active, stk_fault;
  logic        stk_ack = 1'b0;

  io_reg_file_ext_if bus();

  io_reg_file_ext #(
    .SP_WIDTH(SPW), .RAMP_WIDTH(RW), .PC22B(1), .EIND_WIDTH(EW), .CCP_WINDOW(WIN)
  ) dut (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .bus(bus.slave),
    .sreg_fl_in(sreg_fl_in), .sreg_fl_wr_en(sreg_fl_wr_en), .sreg_out(sreg_out),
    .sp_en(sp_en), .sp_ndown_up(sp_ndown_up), .sp_step(sp_step), .sp_out(sp_out),
    .rampd_out(rampd_out), .rampx_out(rampx_out), .rampy_out(rampy_out),
    .rampz_out(rampz_out), .eind_out(eind_out), .ccp_active(ccp_active),
    .stk_fault(stk_fault), .stk_ack(stk_ack)
  );

  always #5 cp2 = ~cp2;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int         m_sp;
  logic [7:0] m_sreg;
  logic [7:0] m_ramp [4];
  logic [7:0] m_eind;
  int         m_ccp_left;   // remaining open cycles of the CCP window
  int         m_splim;
  bit         m_fault;

  task automatic model_reset();
    m_sp = 0; m_sreg = 0; m_eind = 0; m_ccp_left = 0; m_splim = 0; m_fault = 0;
    for (int i = 0; i < 4; i++) m_ramp[i] = 0;
  endtask

  function automatic void model_read(input logic [5:0] a, output logic hit, output logic [7:0] d);
    hit = 1'b1;
    d   = 8'h00;
    if (a >= 6'h38 && a <= 6'h3B) d = m_ramp[a - 6'h38];
    else if (a == 6'h3C) d = m_eind;
    else if (a == 6'h3D) d = 8'(m_sp % 256);
    else if (a == 6'h3E) d = 8'(m_sp / 256);
    else if (a == 6'h3F) d = m_sreg;
    else if (a == 6'h34) d = (m_ccp_left > 0) ? 8'h01 : 8'h00;
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
    else if (a == 6'h32) d = 8'(m_splim % 256);
    else if (a == 6'h33) d = 8'(m_splim / 256);
`endif
    else hit = 1'b0;
    if (!bus.iore) begin hit = 1'b0; d = 8'h00; end
  endfunction

  // Applies one enabled clock edge using the inputs present at that edge.
  task automatic model_update();
    int  modulus = 1 << SPW;
    bit  w = bus.iowe;
    int  a = int'(bus.adr);
    int  d = int'(bus.dbusout);
    int  step = int'(sp_step);
    bit  open = (m_ccp_left > 0);
    bit  new_fault = 1'b0;
    if (w && (a == 'h3D || a == 'h3E)) begin
      if (a == 'h3D) m_sp = (m_sp / 256) * 256 + d;
      else           m_sp = (m_sp % 256) + d * 256;
      m_sp = m_sp % modulus;
    end else if (sp_en && step != 0) begin
      if (sp_ndown_up) m_sp = (m_sp + step) % modulus;
      else begin
        int r = m_sp - step;
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
        if (r < 0 || r < m_splim) new_fault = 1'b1;
        else                      m_sp = r;
`else
        m_sp = (r + modulus) % modulus;
`endif
      end
    end
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
    if (new_fault) m_fault = 1'b1;
    else if (stk_ack) m_fault = 1'b0;
    if (w && open && a == 'h32) m_splim = (m_splim / 256) * 256 + d;
    if (w && open && a == 'h33) m_splim = (m_splim % 256) + d * 256;
`endif
    if (w && a == 'h3F) m_sreg = 8'(d);
    else m_sreg = (m_sreg & ~sreg_fl_wr_en) | (sreg_fl_in & sreg_fl_wr_en);
    if (w && a >= 'h38 && a <= 'h3B) m_ramp[a - 'h38] = 8'(d % (1 << RW));
    if (w && a == 'h3C && open) m_eind = 8'(d % (1 << EW));
    if (w && a == 'h34) m_ccp_left = (d == 'hD8) ? WIN : 0;
    else if (m_ccp_left > 0) m_ccp_left--;
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge cp2) begin
    if (cmp_en) begin
      logic       e_hit;
      logic [7:0] e_d;
      model_read(bus.adr, e_hit, e_d);
      check("sp_out",     sp_out,     16'(m_sp));
      check("sreg_out",   sreg_out,   m_sreg);
      check("rampd_out",  rampd_out,  m_ramp[0]);
      check("rampx_out",  rampx_out,  m_ramp[1]);
      check("rampy_out",  rampy_out,  m_ramp[2]);
      check("rampz_out",  rampz_out,  m_ramp[3]);
      check("eind_out",   eind_out,   m_eind);
      check("ccp_active", ccp_active, m_ccp_left > 0);
      check("stk_fault",  stk_fault,  m_fault);
      check("dbusin",     bus.dbusin, e_d);
      check("io_hit",     bus.io_hit, e_hit);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc();
    @(posedge cp2);
    if (cp2en && ireset) model_update();
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus.iowe = 1'b1; bus.adr = a; bus.dbusout = d;
    cyc();
    bus.iowe = 1'b0;
    $display("wr   adr=%h data=%h sp=%h sreg=%h eind=%h ccp=%b", a, d, sp_out, sreg_out, eind_out, ccp_active);
  endtask

  task automatic sp_op(input logic up, input logic [1:0] st);
    sp_en = 1'b1; sp_ndown_up = up; sp_step = st;
    cyc();
    sp_en = 1'b0; sp_step = 2'd0;
    $display("sp   up=%b step=%0d -> sp=%h fault=%b", up, st, sp_out, stk_fault);
  endtask

  task automatic rd(input logic [5:0] a);
    bus.iore = 1'b1; bus.adr = a;
    #1;
    $display("rd   adr=%h -> dbusin=%h hit=%b", a, bus.dbusin, bus.io_hit);
  endtask

  initial begin
    bus.adr = 6'h00; bus.iowe = 1'b0; bus.iore = 1'b0; bus.dbusout = 8'h00;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) cyc();
    check("reset_sp", sp_out, 16'h0000);
    check("reset_sreg", sreg_out, 16'h0000);
    check("reset_ccp", ccp_active, 16'h0000);
    ireset = 1'b1;

    // SP stepping
    wr(ADR_SPL, 8'h00); wr(ADR_SPH, 8'h01);
    check("sp_load", sp_out, 16'h0100);
    sp_op(1'b0, 2'd3); check("sp_down3", sp_out, 16'h00FD);
    sp_op(1'b1, 2'd2); check("sp_up2",   sp_out, 16'h00FF);
    sp_op(1'b1, 2'd0); check("sp_step0", sp_out, 16'h00FF);

    // Wrap below zero, then write beating count
    wr(ADR_SPL, 8'h00); wr(ADR_SPH, 8'h00);
    sp_op(1'b0, 2'd1);
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
    check("sp_wrap_refused", sp_out, 16'h0000);
    check("wrap_fault", stk_fault, 16'h0001);
    stk_ack = 1'b1; cyc(); stk_ack = 1'b0;
`else
    check("sp_wrap", sp_out, 16'h0FFF);
    check("no_fault", stk_fault, 16'h0000);
`endif
    wr(ADR_SPH, 8'hFF); wr(ADR_SPL, 8'hFF);
    check("sph_mask", sp_out, 16'h0FFF);
    sp_en = 1'b1; sp_ndown_up = 1'b0; sp_step = 2'd1;
    wr(ADR_SPL, 8'h55);
    sp_en = 1'b0; sp_step = 2'd0;
    check("spl_beats_count", sp_out, 16'h0F55);

    // SREG
    sreg_fl_wr_en = 8'hFF; sreg_fl_in = 8'h00;
    wr(ADR_SREG, 8'hA5);
    check("sreg_write", sreg_out, 16'h00A5);
    sreg_fl_wr_en = 8'h01; cyc();
    check("sreg_flag0", sreg_out, 16'h00A4);
    sreg_fl_wr_en = 8'hF0; sreg_fl_in = 8'h3C; cyc();
    check("sreg_flags_hi", sreg_out, 16'h0034);
    sreg_fl_wr_en = 8'h00;

    // Clock enable low: nothing moves
    cp2en = 1'b0;
    wr(ADR_SREG, 8'h00);
    sp_op(1'b1, 2'd3);
    check("cp2en_sreg", sreg_out, 16'h0034);
    check("cp2en_sp", sp_out, 16'h0F55);
    cp2en = 1'b1;

    // CCP / EIND
    wr(ADR_EIND, 8'h01);
    check("eind_locked", eind_out, 16'h0000);
    wr(ADR_CCP, CCP_KEY);
    check("ccp_open", ccp_active, 16'h0001);
    rd(ADR_CCP); check("ccp_read", bus.dbusin, 16'h0001); bus.iore = 1'b0;
    cyc();
    wr(ADR_EIND, 8'h01);
    check("eind_unlocked", eind_out, 16'h0001);
    wr(ADR_CCP, CCP_KEY);
    repeat (WIN) cyc();
    check("ccp_expired", ccp_active, 16'h0000);
    wr(ADR_EIND, 8'h00);
    check("eind_late_drop", eind_out, 16'h0001);
    wr(ADR_CCP, CCP_KEY);
    repeat (WIN - 1) cyc();
    wr(ADR_EIND, 8'h00);
    check("eind_last_cycle", eind_out, 16'h0000);
    wr(ADR_CCP, CCP_KEY);
    wr(ADR_CCP, 8'h00);
    check("ccp_abort", ccp_active, 16'h0000);
    wr(ADR_EIND, 8'h01);
    check("eind_after_abort", eind_out, 16'h0000);
    wr(ADR_CCP, CCP_KEY);
    repeat (2) cyc();
    wr(ADR_CCP, CCP_KEY);
    repeat (3) cyc();
    wr(ADR_EIND, 8'hFF);
    check("eind_reload_mask", eind_out, 16'h0001);

    // Stack limit
`ifdef IO_REG_FILE_EXT_STACK_LIMIT_EN
    wr(ADR_CCP, CCP_KEY);
    wr(ADR_SPLIML, 8'h00); wr(ADR_SPLIMH, 8'h02);
    rd(ADR_SPLIMH); check("splim_read", bus.dbusin, 16'h0002); bus.iore = 1'b0;
    wr(ADR_SPL, 8'h01); wr(ADR_SPH, 8'h02);
    sp_op(1'b0, 2'd2);
    check("limit_sp_hold", sp_out, 16'h0201);
    check("limit_fault", stk_fault, 16'h0001);
    stk_ack = 1'b1; cyc(); stk_ack = 1'b0;
    check("fault_ack", stk_fault, 16'h0000);
    stk_ack = 1'b1; sp_op(1'b0, 2'd3); stk_ack = 1'b0;
    check("fault_beats_ack", stk_fault, 16'h0001);
    stk_ack = 1'b1; sp_op(1'b0, 2'd1); stk_ack = 1'b0;
    check("limit_equal_ok", sp_out, 16'h0200);
    check("ack_clears", stk_fault, 16'h0000);
`else
    rd(6'h32); check("splim_not_decoded", bus.io_hit, 16'h0000); bus.iore = 1'b0;
    wr(ADR_SPL, 8'h01); wr(ADR_SPH, 8'h00);
    sp_op(1'b0, 2'd3);
    check("wrap_no_limit", sp_out, 16'h0FFE);
    check("stk_fault_tied", stk_fault, 16'h0000);
`endif

    // RAMP and read mux
    wr(ADR_RAMPZ, 8'hFF);
    check("rampz_mask", rampz_out, 16'h0001);
    rd(ADR_RAMPZ);
    check("rd_rampz_data", bus.dbusin, 16'h0001);
    check("rd_rampz_hit", bus.io_hit, 16'h0001);
    rd(6'h20);
    check("rd_miss_data", bus.dbusin, 16'h0000);
    check("rd_miss_hit", bus.io_hit, 16'h0000);
    rd(ADR_SPH); cyc();
    bus.iore = 1'b0;

    // Asynchronous reset mid-window
    wr(ADR_RAMPD, 8'h01);
    wr(ADR_CCP, CCP_KEY);
    #3;
    ireset = 1'b0;
    model_reset();
    #1;
    check("arst_sp", sp_out, 16'h0000);
    check("arst_sreg", sreg_out, 16'h0000);
    check("arst_rampd", rampd_out, 16'h0000);
    check("arst_eind", eind_out, 16'h0000);
    check("arst_ccp", ccp_active, 16'h0000);
    cyc();
    ireset = 1'b1;
    wr(ADR_EIND, 8'h01);
    check("eind_after_reset", eind_out, 16'h0000);

    cyc();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
